// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_half_sub.sv
// Combinational half subtractor; two instances plus an OR form a full-subtractor cell.
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial A - B, LSB first, one bit per clock, with a start/busy/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, wdiff_q, wdiff_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q, busy_q, done_q, borrow_q;
  logic             hd0, hb0, d_bit, hb1, bout;

  half_sub u_hs_ab (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .diff   (hd0),
    .borrow (hb0)
  );

  half_sub u_hs_bin (
    .a      (hd0),
    .b      (bin_q),
    .diff   (d_bit),
    .borrow (hb1)
  );

  assign bout = hb0 | hb1;

  // Shift-then-overwrite keeps this valid for WIDTH == 1 without a slice.
  always_comb begin
    wdiff_d            = wdiff_q >> 1;
    wdiff_d[WIDTH-1]   = d_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wdiff_q  <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts start exactly like IDLE, giving back-to-back operation.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            wdiff_q <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          wdiff_q <= wdiff_d;
          bin_q   <= bout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q   <= wdiff_d;
            borrow_q <= bout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
